// File: rtl/stark_fpu_issue_sel.sv
// Issue selector for the FPU reservation station. It finds the oldest ready FPU op,
// counting circularly from the ROB head, and holds the offer until the station accepts it.
module stark_fpu_issue_sel #(
  parameter int unsigned ROB_ENTRIES = 16,
  parameter int unsigned WAITW       = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [$clog2(ROB_ENTRIES)-1:0] head,
  input  logic [ROB_ENTRIES-1:0]         rob_v,
  input  logic [ROB_ENTRIES-1:0]         rob_fpu,
  input  logic [ROB_ENTRIES-1:0]         rob_rdy,
  input  logic [ROB_ENTRIES-1:0]         rob_out,
  input  logic [ROB_ENTRIES-1:0]         stomp,
  input  logic                           flush,
  input  logic                           available,
  input  logic                           idle,
  output logic [$clog2(ROB_ENTRIES)-1:0] rndx,
  output logic                           rndxv,
  output logic                           issued_v,
  output logic [$clog2(ROB_ENTRIES)-1:0] issued_ndx,
  output logic [WAITW-1:0]               wait_cnt
);

  localparam int unsigned NDXW = $clog2(ROB_ENTRIES);

  typedef logic [NDXW-1:0] rob_ndx_t;
  typedef enum logic {IDLE, OFFER} state_e;

  state_e                 state_q, state_d;
  rob_ndx_t               rndx_q, rndx_d;
  logic                   issued_v_q, issued_v_d;
  rob_ndx_t               issued_ndx_q, issued_ndx_d;
  logic [ROB_ENTRIES-1:0] pend_q, pend_d;
  logic [WAITW-1:0]       wait_cnt_q, wait_cnt_d;

  logic [ROB_ENTRIES-1:0] cand;
  logic [ROB_ENTRIES-1:0] rndx_oh;
  logic [NDXW:0]          pick_all;
  logic [NDXW:0]          pick_b2b;
  logic                   offer_q;
  logic                   rndxv_c;
  logic                   accept;

  // Returns {found, index} for the first set mask bit at or after base, wrapping.
  function automatic logic [NDXW:0] pick_oldest(input logic [ROB_ENTRIES-1:0] mask,
                                                input rob_ndx_t base);
    logic [NDXW:0] res;
    rob_ndx_t      idx;
    res = '0;
    for (int k = int'(ROB_ENTRIES) - 1; k >= 0; k--) begin
      idx = base + NDXW'(k);
      if (mask[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  assign cand     = rob_v & rob_fpu & rob_rdy & ~rob_out & ~pend_q & ~stomp;
  assign rndx_oh  = ROB_ENTRIES'(1) << rndx_q;
  assign pick_all = pick_oldest(cand, head);
  // The entry currently on offer cannot be its own back-to-back successor.
  assign pick_b2b = pick_oldest(cand & ~rndx_oh, head);

  // A cancelled or vanished entry is masked the same cycle, so it can never be accepted.
  assign offer_q = (state_q == OFFER);
  assign rndxv_c = offer_q & ~flush & ~stomp[rndx_q] & rob_v[rndx_q];
  assign accept  = rndxv_c & available & idle;

  always_comb begin
    state_d      = state_q;
    rndx_d       = rndx_q;
    issued_v_d   = 1'b0;
    issued_ndx_d = issued_ndx_q;
    wait_cnt_d   = wait_cnt_q;

    pend_d = pend_q & ~(rob_out | ~rob_v | stomp);
    if (accept) pend_d = pend_d | rndx_oh;
    if (flush) pend_d = '0;

    unique case (state_q)
      IDLE: begin
        if (pick_all[NDXW] && !flush) begin
          rndx_d  = pick_all[NDXW-1:0];
          state_d = OFFER;
        end
      end
      OFFER: begin
        if (accept) begin
          issued_v_d   = 1'b1;
          issued_ndx_d = rndx_q;
          if (pick_b2b[NDXW]) begin
            rndx_d = pick_b2b[NDXW-1:0];
          end else begin
            state_d = IDLE;
          end
        end else if (!rndxv_c) begin
          state_d = IDLE;
        end else if (wait_cnt_q != '1) begin
          wait_cnt_d = wait_cnt_q + WAITW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      rndx_q       <= '0;
      issued_v_q   <= 1'b0;
      issued_ndx_q <= '0;
      pend_q       <= '0;
      wait_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      rndx_q       <= rndx_d;
      issued_v_q   <= issued_v_d;
      issued_ndx_q <= issued_ndx_d;
      pend_q       <= pend_d;
      wait_cnt_q   <= wait_cnt_d;
    end
  end

  assign rndx       = rndx_q;
  assign rndxv      = rndxv_c;
  assign issued_v   = issued_v_q;
  assign issued_ndx = issued_ndx_q;
  assign wait_cnt   = wait_cnt_q;

endmodule

// File: tb/tb_stark_fpu_issue_sel.sv
// Directed bench for stark_fpu_issue_sel. A narrow wait counter keeps saturation reachable
// in a short run.
module tb_stark_fpu_issue_sel;

  localparam int unsigned N  = 16;
  localparam int unsigned NW = 4;
  localparam int unsigned WW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [NW-1:0] head;
  logic [N-1:0]  rob_v, rob_fpu, rob_rdy, rob_out, stomp;
  logic          flush, available, idle;
  logic [NW-1:0] rndx, issued_ndx;
  logic          rndxv, issued_v;
  logic [WW-1:0] wait_cnt;

  int checks = 0;
  int errors = 0;

  stark_fpu_issue_sel #(.ROB_ENTRIES(N), .WAITW(WW)) dut (
    .clk(clk), .rst(rst), .head(head),
    .rob_v(rob_v), .rob_fpu(rob_fpu), .rob_rdy(rob_rdy), .rob_out(rob_out), .stomp(stomp),
    .flush(flush), .available(available), .idle(idle),
    .rndx(rndx), .rndxv(rndxv), .issued_v(issued_v), .issued_ndx(issued_ndx),
    .wait_cnt(wait_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add_cand(input int i);
    rob_v[i]   = 1'b1;
    rob_fpu[i] = 1'b1;
    rob_rdy[i] = 1'b1;
  endtask

  task automatic clear_rob();
    rob_v   = '0;
    rob_fpu = '0;
    rob_rdy = '0;
    rob_out = '0;
    stomp   = '0;
  endtask

  initial begin
    rst = 1'b1; head = '0; flush = 1'b0; available = 1'b1; idle = 1'b1;
    clear_rob();
    tick(); tick();
    check_eq("rst_rndx", 32'(rndx), 32'd0);
    check_eq("rst_rndxv", 32'(rndxv), 32'd0);
    check_eq("rst_issued_v", 32'(issued_v), 32'd0);
    check_eq("rst_issued_ndx", 32'(issued_ndx), 32'd0);
    check_eq("rst_wait_cnt", 32'(wait_cnt), 32'd0);
    rst = 1'b0;
    tick(); tick();
    check_eq("empty_rndxv", 32'(rndxv), 32'd0);

    // Single offer with one-cycle select latency.
    add_cand(3);
    #1 check_eq("t1_latency", 32'(rndxv), 32'd0);
    tick();
    check_eq("t1_rndxv", 32'(rndxv), 32'd1);
    check_eq("t1_rndx", 32'(rndx), 32'd3);
    tick();
    check_eq("t1_issued_v", 32'(issued_v), 32'd1);
    check_eq("t1_issued_ndx", 32'(issued_ndx), 32'd3);
    check_eq("t1_rndxv_idle", 32'(rndxv), 32'd0);
    rob_out[3] = 1'b1;
    tick();
    check_eq("t1_pulse_end", 32'(issued_v), 32'd0);
    clear_rob();
    tick();

    // Circular scan from head 14 picks 15 before 2, then issues back to back.
    head = 4'd14;
    add_cand(2); add_cand(15);
    tick();
    check_eq("t2_first", 32'(rndx), 32'd15);
    check_eq("t2_first_v", 32'(rndxv), 32'd1);
    tick();
    check_eq("t2_second", 32'(rndx), 32'd2);
    check_eq("t2_second_v", 32'(rndxv), 32'd1);
    check_eq("t2_issued15", 32'(issued_ndx), 32'd15);
    check_eq("t2_issued15_v", 32'(issued_v), 32'd1);
    rob_out[15] = 1'b1;
    tick();
    check_eq("t2_issued2", 32'(issued_ndx), 32'd2);
    check_eq("t2_issued2_v", 32'(issued_v), 32'd1);
    check_eq("t2_done", 32'(rndxv), 32'd0);
    clear_rob();
    tick();
    check_eq("t2_pulse_end", 32'(issued_v), 32'd0);

    // Hold while the station is busy, then accept.
    head = '0; idle = 1'b0;
    add_cand(5);
    tick();
    check_eq("t3_offer", 32'(rndx), 32'd5);
    for (int i = 0; i < 4; i++) tick();
    check_eq("t3_hold_rndx", 32'(rndx), 32'd5);
    check_eq("t3_hold_v", 32'(rndxv), 32'd1);
    check_eq("t3_wait_cnt", 32'(wait_cnt), 32'd4);
    check_eq("t3_no_issue", 32'(issued_v), 32'd0);
    idle = 1'b1;
    tick();
    check_eq("t3_issued_v", 32'(issued_v), 32'd1);
    check_eq("t3_issued_ndx", 32'(issued_ndx), 32'd5);
    check_eq("t3_wait_keep", 32'(wait_cnt), 32'd4);
    clear_rob();
    tick();

    // Stomp on the offered entry masks it in the same cycle.
    add_cand(7);
    tick();
    check_eq("t4_offer", 32'(rndx), 32'd7);
    stomp[7] = 1'b1;
    #1 check_eq("t4_masked", 32'(rndxv), 32'd0);
    tick();
    check_eq("t4_no_issue", 32'(issued_v), 32'd0);
    check_eq("t4_idle", 32'(rndxv), 32'd0);
    clear_rob();
    tick();
    check_eq("t4_still_idle", 32'(rndxv), 32'd0);

    // Pending entry is not re-offered until the ROB out bit arrives.
    add_cand(9);
    tick();
    check_eq("t5_offer", 32'(rndx), 32'd9);
    tick();
    check_eq("t5_issued", 32'(issued_ndx), 32'd9);
    check_eq("t5_issued_v", 32'(issued_v), 32'd1);
    for (int i = 0; i < 3; i++) begin
      check_eq("t5_no_reoffer", 32'(rndxv), 32'd0);
      tick();
    end
    check_eq("t5_single_pulse", 32'(issued_v), 32'd0);
    rob_out[9] = 1'b1;
    tick();
    rob_out[9] = 1'b0;
    tick();
    check_eq("t5_pend_clear_v", 32'(rndxv), 32'd1);
    check_eq("t5_pend_clear", 32'(rndx), 32'd9);
    rob_v = '0;
    tick();
    check_eq("t5_vanish_no_issue", 32'(issued_v), 32'd0);
    clear_rob();
    tick();

    // Flush cancels an offer.
    add_cand(11);
    tick();
    flush = 1'b1;
    #1 check_eq("fl_masked", 32'(rndxv), 32'd0);
    tick();
    flush = 1'b0;
    check_eq("fl_no_issue", 32'(issued_v), 32'd0);
    clear_rob();
    tick();

    // Saturation of the wait counter, then reset while offering.
    idle = 1'b0;
    add_cand(4);
    tick();
    for (int i = 0; i < 20; i++) tick();
    check_eq("t6_sat", 32'(wait_cnt), 32'd15);
    tick();
    check_eq("t6_sat_hold", 32'(wait_cnt), 32'd15);
    rst = 1'b1;
    tick();
    check_eq("t6_rst_rndxv", 32'(rndxv), 32'd0);
    check_eq("t6_rst_rndx", 32'(rndx), 32'd0);
    check_eq("t6_rst_issued_v", 32'(issued_v), 32'd0);
    check_eq("t6_rst_issued_ndx", 32'(issued_ndx), 32'd0);
    check_eq("t6_rst_wait", 32'(wait_cnt), 32'd0);
    rst = 1'b0; idle = 1'b1;
    tick();
    check_eq("t6_reoffer", 32'(rndx), 32'd4);
    tick();
    check_eq("t6_issued", 32'(issued_ndx), 32'd4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
